// File: rtl/wallace_final_adder.sv
// wallace_final_adder: two-stage pipelined carry-propagate add of Wallace sum/carry vectors
module wallace_final_adder #(
  parameter int WIDTH = 32,
  parameter int SPLIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] add_out1,
  input  logic [WIDTH-1:0] add_out0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product
);
  logic                   r_s1_valid;
  logic                   r_s2_valid;
  logic [SPLIT:0]         r_s1_lo;
  logic [WIDTH-SPLIT-1:0] r_s1_hi1;
  logic [WIDTH-SPLIT-1:0] r_s1_hi0;
  logic [WIDTH-1:0]       r_product;
  logic                   w_s2_adv;
  logic                   w_accept;
  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_adv;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_s2_valid;
  assign product   = r_product;
  always_ff @(posedge clk)
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s1_lo    <= '0;
      r_s1_hi1   <= '0;
      r_s1_hi0   <= '0;
      r_product  <= '0;
    end else begin
      r_s1_valid <= w_accept || (r_s1_valid && !w_s2_adv);
      if (w_accept) begin
        r_s1_lo  <= {1'b0, add_out1[SPLIT-1:0]} + {1'b0, add_out0[SPLIT-1:0]};
        r_s1_hi1 <= add_out1[WIDTH-1:SPLIT];
        r_s1_hi0 <= add_out0[WIDTH-1:SPLIT];
      end
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
      // product only updates with real data, so idle cycles never disturb it
      if (w_s2_adv && r_s1_valid)
        r_product <= {r_s1_hi1 + r_s1_hi0 + {{(WIDTH-SPLIT-1){1'b0}}, r_s1_lo[SPLIT]}, r_s1_lo[SPLIT-1:0]};
    end
endmodule

// File: tb/tb_wallace_final_adder.sv
// tb_wallace_final_adder: directed table and sequence checks of the pipelined final adder
module tb_wallace_final_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] add_out1;
  logic [31:0] add_out0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  int          checks = 0;
  int          errors = 0;
  typedef struct {logic [31:0] a; logic [31:0] b; logic [31:0] exp;} vec_t;
  vec_t tbl[14];
  wallace_final_adder #(.WIDTH(32), .SPLIT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .add_out1(add_out1), .add_out0(add_out0), .out_valid(out_valid),
    .out_ready(out_ready), .product(product)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    add_out1 = v ? a : $urandom;
    add_out0 = v ? b : $urandom;
  endtask
  initial begin
    tbl[0]  = '{32'h0000_05DC, 32'h0000_0000, 32'd1500};
    tbl[1]  = '{32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000};
    tbl[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    tbl[3]  = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    tbl[4]  = '{32'h1234_8000, 32'h0000_8000, 32'h1235_0000};
    tbl[5]  = '{32'hA5A5_1234, 32'h5A5A_4321, 32'hFFFF_5555};
    for (int i = 1; i <= 8; i++) tbl[5+i] = '{i, i, 2*i};
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'd7, 32'd9);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset product", product, 32'd0);
    rst = 1'b0; drive(1'b0, 0, 0);
    chk("in_ready after reset", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    chk("no accept during reset", {31'b0, out_valid}, 32'd0);
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      if (k >= 1) chk($sformatf("stream in_ready %0d", k), {31'b0, in_ready}, 32'd1);
      if (k == 1) chk("latency not early", {31'b0, out_valid}, 32'd0);
      if (k >= 2) begin
        chk($sformatf("stream out_valid %0d", k-2), {31'b0, out_valid}, 32'd1);
        chk($sformatf("stream product %0d", k-2), product, tbl[k-2].exp);
      end
      if (k < 14) drive(1'b1, tbl[k].a, tbl[k].b);
      else drive(1'b0, 0, 0);
    end
    @(negedge clk);
    chk("stream drained", {31'b0, out_valid}, 32'd0);
    chk("idle product holds", product, tbl[13].exp);
    out_ready = 1'b0;
    drive(1'b1, 32'd1, 32'd2);
    @(negedge clk);
    chk("bp accept A", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 32'd3, 32'd4);
    @(negedge clk);
    chk("bp full in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp A valid", {31'b0, out_valid}, 32'd1);
    chk("bp A product", product, 32'd3);
    drive(1'b1, 32'd5, 32'd6);
    repeat (2) begin
      @(negedge clk);
      chk("bp hold in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp hold valid", {31'b0, out_valid}, 32'd1);
      chk("bp hold product", product, 32'd3);
    end
    out_ready = 1'b1;
    #1 chk("bp release in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    drive(1'b0, 0, 0);
    chk("bp B valid", {31'b0, out_valid}, 32'd1);
    chk("bp B product", product, 32'd7);
    @(negedge clk);
    chk("bp C valid", {31'b0, out_valid}, 32'd1);
    chk("bp C product", product, 32'd11);
    @(negedge clk);
    chk("bp drained", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'd10, 32'd0);
    @(negedge clk);
    drive(1'b1, 32'd20, 32'd0);
    @(negedge clk);
    drive(1'b0, 0, 0);
    chk("mid-reset pre valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid-reset product", product, 32'd0);
    chk("mid-reset in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    drive(1'b1, 32'd100, 32'd23);
    @(negedge clk);
    drive(1'b0, 0, 0);
    chk("post-reset latency", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("post-reset valid", {31'b0, out_valid}, 32'd1);
    chk("post-reset product", product, 32'd123);
    @(negedge clk);
    chk("post-reset no stale", {31'b0, out_valid}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
